image_inverter: RTL and testbench
=================================

IMAGE_INVERTER -- requirements
Module: image_inverter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 25344, meaning 32-bit words in the source image (101376 pixels / 4).
REQ-002 SHALL have parameter OUT_OFFSET, default 25344, meaning word offset of the result image in memory.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin processing, level-sampled in IDLE.
REQ-006 SHALL have port finish  output  1  processing complete; drives memory dump_image.
REQ-007 SHALL have port en  output  1  memory access enable.
REQ-008 SHALL have port we  output  1  memory write enable; asserted only together with en.
REQ-009 SHALL have port addr  output  16  memory word address.
REQ-010 SHALL have port dataW  output  32  write data to memory.
REQ-011 SHALL have port dataR  input  32  memory read data, valid the cycle after a read (read-first, 1-cycle latency).

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-013 SHALL move IDLE->READ on the first rising edge where start=1; otherwise stay in IDLE.
REQ-014 SHALL in READ drive en=1, we=0, addr=idx; next state WRITE.
REQ-015 SHALL in WRITE drive en=1, we=1, addr=idx+OUT_OFFSET, dataW=~dataR (bitwise; each byte p becomes 255-p).
REQ-016 SHALL in WRITE increment idx and go to READ if idx<NUM_WORDS-1, else clear idx and go to DONE.
REQ-017 SHALL hold idx as a 15-bit unsigned counter; addr SHALL be the zero-extended 16-bit sum, no wrap (max 50687).
REQ-018 SHALL in DONE drive finish=1, en=0, we=0; stay while start=1; go to IDLE when start=0.
REQ-019 SHALL in IDLE and DONE drive en=0, we=0, addr=0, dataW=0.
REQ-020 SHALL ignore start outside IDLE; a one-cycle start pulse SHALL suffice.
REQ-021 SHALL complete in exactly 2*NUM_WORDS cycles from the first READ cycle; finish first high in cycle 2*NUM_WORDS+1 after start was sampled.
REQ-022 SHALL drive outputs as Moore functions of state and idx, except dataW, which is combinational from dataR in WRITE.
REQ-023 SHALL never issue a write to an address below OUT_OFFSET.

Reset
REQ-024 SHALL on reset=1 at a clock edge enter IDLE, clear idx, and give finish=0, en=0, we=0, addr=0, dataW=0 from the next cycle.
REQ-025 SHALL abort any operation on mid-operation reset, with no further memory access; the next start SHALL restart from word 0.
REQ-026 SHALL give reset priority over start when both are 1.

Structure
REQ-027 SHALL take IMG_WORDS=25344, RESULT_OFFSET=25344, ADDR_W=16, DATA_W=32 and the state enum type from shared package accel_pkg.
REQ-028 SHALL be a single module without sub-modules; parameter defaults SHALL come from accel_pkg constants.

Verification
REQ-029 SHALL cover reset: reset=1 for 2 cycles during WRITE -> IDLE next cycle, en=we=finish=0, addr=0.
REQ-030 SHALL cover a small image: NUM_WORDS=4, OUT_OFFSET=4, word0=0x00FF10A5 -> word4=0xFF00EF5A; addr sequence 0,4,1,5,2,6,3,7; finish high in cycle 9.
REQ-031 SHALL cover a full image with the project memory and a 101376-pixel PGM -> finish high 50689 cycles after start; every dumped pixel equals 255 minus the source pixel; source half unchanged.
REQ-032 SHALL cover reset mid-run at idx=100, then start -> first access is READ of addr 0.
REQ-033 SHALL cover the start handshake: start held high through DONE -> finish stays 1; start=0 -> IDLE next cycle, finish=0; second start reruns the full sequence.
REQ-034 SHALL cover a one-cycle start pulse -> complete run; start toggling mid-run -> no effect on the address sequence.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared constants and types for the image accelerator: memory geometry,
// the inverter FSM state encoding and the pixel inversion helper.
package accel_pkg;

    localparam int unsigned IMG_WORDS     = 25344;
    localparam int unsigned RESULT_OFFSET = 25344;
    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned IDX_W         = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bitwise complement turns every 8-bit pixel p into 255-p.
    function automatic logic [DATA_W-1:0] invert_word(input logic [DATA_W-1:0] w);
        return ~w;
    endfunction

endpackage

// File: rtl/image_inverter.sv
// Streams an image from memory word by word, writing the inverted pixels to a
// second region at OUT_OFFSET, alternating one read and one write cycle.
module image_inverter
    import accel_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = IMG_WORDS,
    parameter int unsigned OUT_OFFSET = RESULT_OFFSET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataW,
    input  logic [DATA_W-1:0] dataR
);

    localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] OutBase = ADDR_W'(OUT_OFFSET);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = READ;
            end
            READ: begin
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q < LastIdx) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = READ;
                end else begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Hold here until start drops so one long start level runs only once.
                if (!start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Moore outputs; dataW alone follows dataR combinationally during WRITE.
    always_comb begin
        finish = 1'b0;
        en     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        dataW  = '0;
        case (state_q)
            READ: begin
                en   = 1'b1;
                addr = ADDR_W'(idx_q);
            end
            WRITE: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = ADDR_W'(idx_q) + OutBase;
                dataW = invert_word(dataR);
            end
            DONE: begin
                finish = 1'b1;
            end
            default: begin
                finish = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_image_inverter.sv
// Directed bench: a 4-word instance for sequence/handshake/reset cases and a
// default-size instance for the full-image run and a mid-run reset.
module tb_image_inverter;
    import accel_pkg::*;

    localparam int unsigned SN = 4;
    localparam int unsigned SO = 4;
    localparam int unsigned BN = IMG_WORDS;
    localparam int unsigned BO = RESULT_OFFSET;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset, s_start, s_finish, s_en, s_we;
    logic [15:0] s_addr;
    logic [31:0] s_dataW, s_dataR;
    logic        b_reset, b_start, b_finish, b_en, b_we;
    logic [15:0] b_addr;
    logic [31:0] b_dataW, b_dataR;

    logic [31:0] s_mem [0:7];
    logic [31:0] b_mem [0:65535];
    logic [31:0] b_src [0:BN-1];

    int n_vec = 0;
    int n_err = 0;

    image_inverter #(
        .NUM_WORDS (SN),
        .OUT_OFFSET(SO)
    ) u_small (
        .clk   (clk),
        .reset (s_reset),
        .start (s_start),
        .finish(s_finish),
        .en    (s_en),
        .we    (s_we),
        .addr  (s_addr),
        .dataW (s_dataW),
        .dataR (s_dataR)
    );

    image_inverter u_big (
        .clk   (clk),
        .reset (b_reset),
        .start (b_start),
        .finish(b_finish),
        .en    (b_en),
        .we    (b_we),
        .addr  (b_addr),
        .dataW (b_dataW),
        .dataR (b_dataR)
    );

    // Read-first memories with one cycle of read latency.
    always @(posedge clk) begin
        if (s_en) begin
            s_dataR <= s_mem[s_addr[2:0]];
            if (s_we) s_mem[s_addr[2:0]] <= s_dataW;
        end
        if (b_en) begin
            b_dataR <= b_mem[b_addr];
            if (b_we) b_mem[b_addr] <= b_dataW;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input logic fin_exp);
        check_eq({tag, ".finish"}, 32'(s_finish), 32'(fin_exp));
        check_eq({tag, ".en"}, 32'(s_en), 32'd0);
        check_eq({tag, ".we"}, 32'(s_we), 32'd0);
        check_eq({tag, ".addr"}, 32'(s_addr), 32'd0);
        check_eq({tag, ".dataW"}, s_dataW, 32'd0);
    endtask

    // One run of the small instance from IDLE; cycle 1 is the first READ.
    task automatic run_small(input bit toggle, input bit hold, input string tag);
        logic [31:0] src [SN];
        for (int i = 0; i < int'(SN); i++) src[i] = s_mem[i];
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int k = 1; k <= int'(2 * SN); k++) begin
            logic        wr;
            logic [31:0] ea;
            wr = (k % 2 == 0);
            ea = wr ? 32'(k / 2 - 1 + int'(SO)) : 32'((k - 1) / 2);
            check_eq({tag, ".en"}, 32'(s_en), 32'd1);
            check_eq({tag, ".we"}, 32'(s_we), 32'(wr));
            check_eq({tag, ".addr"}, 32'(s_addr), ea);
            if (wr) check_eq({tag, ".dataW"}, s_dataW, ~src[k/2-1]);
            check_eq({tag, ".finish_low"}, 32'(s_finish), 32'd0);
            s_start = toggle ? logic'(k % 2) : 1'b0;
            if (hold && k == int'(2 * SN)) s_start = 1'b1;
            step();
        end
        check_idle_outputs({tag, ".done"}, 1'b1);
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                step();
                check_eq({tag, ".hold_finish"}, 32'(s_finish), 32'd1);
            end
        end
        s_start = 1'b0;
        step();
        check_idle_outputs({tag, ".back_idle"}, 1'b0);
        for (int i = 0; i < int'(SN); i++) begin
            check_eq({tag, ".dst"}, s_mem[int'(SO) + i], ~src[i]);
            check_eq({tag, ".src"}, s_mem[i], src[i]);
        end
    endtask

    initial begin
        int cyc;
        int bad_seq;
        int low_wr;
        int bad_dst;
        int bad_src;
        logic [31:0] ea;

        s_reset = 1'b1;
        s_start = 1'b0;
        b_reset = 1'b1;
        b_start = 1'b0;
        s_mem[0] = 32'h00FF10A5;
        s_mem[1] = 32'h12345678;
        s_mem[2] = 32'hFFFFFFFF;
        s_mem[3] = 32'h00000000;
        for (int i = 4; i < 8; i++) s_mem[i] = 32'hDEADBEEF;
        for (int i = 0; i < 65536; i++) b_mem[i] = 32'd0;
        for (int i = 0; i < int'(BN); i++) begin
            b_src[i] = (32'(i) * 32'h9E3779B1) ^ 32'h00FF10A5;
            b_mem[i] = b_src[i];
        end

        step();
        step();
        check_idle_outputs("reset", 1'b0);
        check_eq("big.reset.en", 32'(b_en), 32'd0);
        check_eq("big.reset.finish", 32'(b_finish), 32'd0);
        s_reset = 1'b0;
        b_reset = 1'b0;
        step();
        check_idle_outputs("idle_no_start", 1'b0);

        run_small(1'b0, 1'b0, "pulse");
        check_eq("pulse.word4", s_mem[4], 32'hFF00EF5A);
        run_small(1'b1, 1'b0, "toggle");
        run_small(1'b0, 1'b1, "hold");

        // Reset held two cycles starting in a WRITE cycle, with start raised too.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        step();
        check_eq("pre_rst.we", 32'(s_we), 32'd1);
        s_reset = 1'b1;
        step();
        check_idle_outputs("rst_write", 1'b0);
        s_start = 1'b1;
        step();
        check_idle_outputs("rst_priority", 1'b0);
        s_reset = 1'b0;
        s_start = 1'b0;
        step();
        check_idle_outputs("rst_release", 1'b0);
        run_small(1'b0, 1'b0, "after_rst");

        // Full-size instance: abort at idx=100, then restart and run to completion.
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int k = 1; k < 201; k++) step();
        check_eq("big.mid.addr", 32'(b_addr), 32'd100);
        check_eq("big.mid.we", 32'(b_we), 32'd0);
        b_reset = 1'b1;
        step();
        check_eq("big.abort.en", 32'(b_en), 32'd0);
        b_reset = 1'b0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check_eq("big.restart.en", 32'(b_en), 32'd1);
        check_eq("big.restart.we", 32'(b_we), 32'd0);
        check_eq("big.restart.addr", 32'(b_addr), 32'd0);

        cyc = 1;
        bad_seq = 0;
        low_wr = 0;
        while (!b_finish && cyc <= int'(2 * BN) + 10) begin
            ea = (cyc % 2 == 0) ? 32'(cyc / 2 - 1 + int'(BO)) : 32'((cyc - 1) / 2);
            if (b_en !== 1'b1 || b_we !== logic'(cyc % 2 == 0) || 32'(b_addr) !== ea)
                bad_seq++;
            if (b_we && 32'(b_addr) < BO) low_wr++;
            b_start = (cyc < int'(2 * BN)) ? logic'($urandom_range(0, 1)) : 1'b0;
            step();
            cyc++;
        end
        b_start = 1'b0;
        check_eq("big.finish", 32'(b_finish), 32'd1);
        check_eq("big.latency", 32'(cyc), 32'(2 * BN + 1));
        check_eq("big.addr_seq_errors", 32'(bad_seq), 32'd0);
        check_eq("big.low_writes", 32'(low_wr), 32'd0);
        step();
        check_eq("big.idle.finish", 32'(b_finish), 32'd0);

        bad_dst = 0;
        bad_src = 0;
        for (int i = 0; i < int'(BN); i++) begin
            if (b_mem[int'(BO) + i] !== ~b_src[i]) bad_dst++;
            if (b_mem[i] !== b_src[i]) bad_src++;
        end
        check_eq("big.dst_errors", 32'(bad_dst), 32'd0);
        check_eq("big.src_errors", 32'(bad_src), 32'd0);
        check_eq("big.dst0", b_mem[BO], 32'hFF00EF5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
